// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types for the FIFO write-port arbiter.
// FSM state encoding and a constant-safe clog2.
package fifo_wr_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker.
// Returns the first set request at or after ptr, cyclically.
module rr_pick
  import fifo_wr_arb_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  int w_dist;
  int w_best;

  // keep the requester with the smallest cyclic distance from ptr
  always_comb begin
    gnt_idx = '0;
    any     = 1'b0;
    w_dist  = 0;
    w_best  = N;
    for (int i = 0; i < N; i++) begin
      if (req[i]) begin
        w_dist = (i + N - int'(ptr)) % N;
        if (w_dist < w_best) begin
          w_best  = w_dist;
          gnt_idx = IW'(i);
          any     = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, packet-locked arbiter for the FIFO write port.
// Grants are capped at MAX_BEATS beats to avoid starvation.
module fifo_wr_arbiter
  import fifo_wr_arb_pkg::*;
#(
  parameter  int N         = 4,
  parameter  int DW        = 8,
  parameter  int MAX_BEATS = 16,
  localparam int IW        = clog2(N),
  localparam int CW        = clog2(MAX_BEATS + 1)
) (
  input  logic            wclk,
  input  logic            wrst,
  input  logic [N-1:0]    req_valid,
  input  logic [N*DW-1:0] req_data,
  input  logic [N-1:0]    req_last,
  output logic [N-1:0]    req_ready,
  input  logic            wfull,
  output logic            winc,
  output logic [DW-1:0]   wdata,
  output logic [IW-1:0]   grant_id,
  output logic            busy,
  output logic            trunc_err
);

  state_t        r_state;
  state_t        w_state_nx;
  logic [IW-1:0] r_ptr;
  logic [IW-1:0] w_ptr_nx;
  logic [IW-1:0] r_gid;
  logic [IW-1:0] w_gid_inc;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nx;
  logic          r_trunc;
  logic          w_trunc_nx;
  logic [IW-1:0] w_pick;
  logic          w_any;
  logic          w_open;
  logic          w_acc;
  logic          w_last;
  logic          w_cap;
  logic [DW-1:0] w_beat [N];

  rr_pick #(
    .N(N)
  ) u_pick (
    .req     (req_valid),
    .ptr     (r_ptr),
    .gnt_idx (w_pick),
    .any     (w_any)
  );

  // split the flat data bus into per-requester beats
  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_beat[i] = req_data[i*DW +: DW];
    end
  end

  assign w_open    = (r_state == GRANT) & ~wfull & ~wrst;
  assign w_acc     = w_open & req_valid[r_gid];
  assign w_last    = req_last[r_gid];
  assign w_cnt_nx  = r_cnt + 1'b1;
  assign w_cap     = (w_cnt_nx == CW'(MAX_BEATS));
  assign w_gid_inc = (r_gid == IW'(N - 1)) ? '0 : r_gid + 1'b1;

  assign winc      = w_acc;
  assign wdata     = w_beat[r_gid];
  assign grant_id  = r_gid;
  assign busy      = (r_state == GRANT);
  assign trunc_err = r_trunc;

  // only the grant holder sees ready, and only when the FIFO has room
  always_comb begin
    req_ready = '0;
    if (w_open) req_ready[r_gid] = 1'b1;
  end

  // next state, release pointer and truncation flag
  always_comb begin
    w_state_nx = r_state;
    w_ptr_nx   = r_ptr;
    w_trunc_nx = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_any) w_state_nx = GRANT;
      end
      GRANT: begin
        if (w_acc && (w_last || w_cap)) begin
          w_state_nx = IDLE;
          w_ptr_nx   = w_gid_inc;
          w_trunc_nx = ~w_last;
        end
      end
    endcase
  end

  // state, grant, beat counter and error registers
  always_ff @(posedge wclk) begin
    if (wrst) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_gid   <= '0;
      r_cnt   <= '0;
      r_trunc <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_ptr   <= w_ptr_nx;
      r_trunc <= w_trunc_nx;
      if (r_state == IDLE && w_any) begin
        r_gid <= w_pick;
        r_cnt <= '0;
      end else if (w_acc) begin
        r_cnt <= w_cnt_nx;
      end
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter.
// Table vectors, directed corner cases, random vs reference model.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int MB = 4;

  logic       wclk = 1'b0;
  logic       wrst = 1'b1;
  logic [3:0] req_valid = '0;
  logic [3:0] req_last = '0;
  logic [31:0] req_data = '0;
  logic       wfull = 1'b0;
  logic [3:0] req_ready;
  logic       winc;
  logic [7:0] wdata;
  logic [1:0] grant_id;
  logic       busy;
  logic       trunc_err;

  always #5 wclk = ~wclk;

  fifo_wr_arbiter #(
    .N(4), .DW(8), .MAX_BEATS(MB)
  ) dut (
    .wclk      (wclk),
    .wrst      (wrst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .wfull     (wfull),
    .winc      (winc),
    .wdata     (wdata),
    .grant_id  (grant_id),
    .busy      (busy),
    .trunc_err (trunc_err)
  );

  int n_run = 0;
  int n_fail = 0;

  // reference model: who owns the port, beats taken, next start point
  int m_busy = 0, m_own = 0, m_cnt = 0, m_ptr = 0, m_trunc = 0;

  logic       s_winc, s_busy, s_trunc;
  logic [7:0] s_wdata;
  logic [1:0] s_gid;
  logic [3:0] s_ready;
  logic [7:0] wlog[$];
  int         wcyc[$];
  int         ccount = 0;

  int src_rem[4] = '{default: 0};
  int src_sent[4] = '{default: 0};
  bit src_nolast[4] = '{default: 0};
  bit src_mode = 0;
  bit src_refill = 0;

  typedef struct {
    logic [3:0]  v;
    logic [31:0] d;
    logic [3:0]  l;
    logic        wf;
    logic        e_winc;
    logic [7:0]  e_wdata;
    logic [3:0]  e_ready;
    logic        e_busy;
    logic [1:0]  e_gid;
    logic        e_trunc;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive_srcs();
    for (int i = 0; i < 4; i++) begin
      req_valid[i] = src_rem[i] > 0;
      req_last[i]  = (src_rem[i] == 1) && !src_nolast[i];
      req_data[i*8 +: 8] = {4'(i), 4'(src_sent[i])};
    end
  endtask

  task automatic model_step(logic ew);
    int cand;
    if (wrst) begin
      m_busy = 0; m_own = 0; m_cnt = 0; m_ptr = 0; m_trunc = 0;
    end else begin
      m_trunc = 0;
      if (m_busy == 0) begin
        if (req_valid != 0) begin
          for (int k = N - 1; k >= 0; k--) begin
            cand = (m_ptr + k) % N;
            if (req_valid[cand]) m_own = cand;
          end
          m_busy = 1;
          m_cnt = 0;
        end
      end else if (ew) begin
        m_cnt++;
        if (req_last[m_own] || m_cnt == MB) begin
          m_trunc = req_last[m_own] ? 0 : 1;
          m_busy = 0;
          m_ptr = (m_own + 1) % N;
        end
      end
    end
  endtask

  task automatic cyc();
    logic       ew;
    logic [3:0] er;
    logic [3:0] acc;
    @(negedge wclk);
    ew = !wrst && m_busy != 0 && req_valid[m_own] && !wfull;
    er = '0;
    if (!wrst && m_busy != 0 && !wfull) er[m_own] = 1'b1;
    s_winc = winc; s_busy = busy; s_trunc = trunc_err;
    s_wdata = wdata; s_gid = grant_id; s_ready = req_ready;
    chk("winc", winc, ew);
    chk("req_ready", req_ready, er);
    chk("busy", busy, m_busy != 0);
    chk("trunc_err", trunc_err, m_trunc != 0);
    if (m_busy != 0) chk("grant_id", grant_id, m_own);
    if (ew) chk("wdata", wdata, req_data[m_own*8 +: 8]);
    if (winc) begin
      wlog.push_back(wdata);
      wcyc.push_back(ccount);
    end
    acc = req_valid & req_ready;
    @(posedge wclk);
    model_step(ew);
    ccount++;
    #1;
    if (src_mode) begin
      for (int i = 0; i < 4; i++) begin
        if (acc[i]) begin
          src_sent[i]++;
          src_rem[i]--;
          if (src_refill && src_rem[i] == 0) src_rem[i] = 1;
        end
      end
      drive_srcs();
    end
  endtask

  task automatic do_reset();
    for (int i = 0; i < 4; i++) begin
      src_rem[i] = 0; src_sent[i] = 0; src_nolast[i] = 0;
    end
    req_valid = '0; req_last = '0; req_data = '0;
    wfull = 1'b0; wrst = 1'b1;
    cyc();
    wrst = 1'b0;
  endtask

  int base, nw, tcnt;
  logic [7:0] b0, b1;

  initial begin
    tbl[0] = '{4'b0100, 32'h00A10000, 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd0, 1'b0};
    tbl[1] = '{4'b0100, 32'h00A10000, 4'b0000, 1'b0, 1'b1, 8'hA1, 4'b0100, 1'b1, 2'd2, 1'b0};
    tbl[2] = '{4'b0100, 32'h00A20000, 4'b0000, 1'b0, 1'b1, 8'hA2, 4'b0100, 1'b1, 2'd2, 1'b0};
    tbl[3] = '{4'b0100, 32'h00A30000, 4'b0100, 1'b0, 1'b1, 8'hA3, 4'b0100, 1'b1, 2'd2, 1'b0};
    tbl[4] = '{4'b0000, 32'h00000000, 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd0, 1'b0};
    tbl[5] = '{4'b1111, 32'h44332211, 4'b1111, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd0, 1'b0};
    tbl[6] = '{4'b1111, 32'h44332211, 4'b1111, 1'b0, 1'b1, 8'h44, 4'b1000, 1'b1, 2'd3, 1'b0};
    tbl[7] = '{4'b0000, 32'h00000000, 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd0, 1'b0};

    @(posedge wclk);
    #1;
    cyc();
    chk("rst_busy", s_busy, 1'b0);
    chk("rst_gid", s_gid, 2'd0);
    chk("rst_winc", s_winc, 1'b0);
    chk("rst_ready", s_ready, 4'b0);
    chk("rst_trunc", s_trunc, 1'b0);
    wrst = 1'b0;

    // single packet from req 2, then req 3 wins from rr_ptr=3
    for (int r = 0; r < 8; r++) begin
      req_valid = tbl[r].v; req_data = tbl[r].d;
      req_last = tbl[r].l; wfull = tbl[r].wf;
      cyc();
      chk($sformatf("tbl%0d_winc", r), s_winc, tbl[r].e_winc);
      chk($sformatf("tbl%0d_ready", r), s_ready, tbl[r].e_ready);
      chk($sformatf("tbl%0d_busy", r), s_busy, tbl[r].e_busy);
      chk($sformatf("tbl%0d_trunc", r), s_trunc, tbl[r].e_trunc);
      if (tbl[r].e_busy) chk($sformatf("tbl%0d_gid", r), s_gid, tbl[r].e_gid);
      if (tbl[r].e_winc) chk($sformatf("tbl%0d_wdata", r), s_wdata, tbl[r].e_wdata);
    end

    src_mode = 1;

    // fairness: grants 0,1,2,3,0 two cycles apart
    do_reset();
    src_refill = 1;
    for (int i = 0; i < 4; i++) src_rem[i] = 1;
    drive_srcs();
    base = wlog.size();
    repeat (10) cyc();
    src_refill = 0;
    chk("fair_count", wlog.size() - base, 5);
    if (wlog.size() - base >= 5) begin
      for (int k = 0; k < 5; k++) begin
        b0 = wlog[base + k];
        chk($sformatf("fair_id%0d", k), b0[7:4], k % 4);
        if (k > 0) chk($sformatf("fair_gap%0d", k), wcyc[base + k] - wcyc[base + k - 1], 2);
      end
    end

    // backpressure mid-packet
    do_reset();
    src_rem[1] = 3;
    drive_srcs();
    cyc();
    cyc();
    wfull = 1'b1;
    nw = wlog.size();
    repeat (5) cyc();
    chk("bp_writes", wlog.size() - nw, 0);
    chk("bp_busy", s_busy, 1'b1);
    chk("bp_gid", s_gid, 2'd1);
    wfull = 1'b0;
    cyc();
    chk("bp_resume_winc", s_winc, 1'b1);
    chk("bp_resume_data", s_wdata, 8'h11);
    cyc();
    chk("bp_last_data", s_wdata, 8'h12);

    // truncation at MAX_BEATS, pending req 2 served next
    do_reset();
    src_nolast[1] = 1;
    src_rem[1] = 6;
    src_rem[2] = 1;
    drive_srcs();
    base = wlog.size();
    tcnt = 0;
    repeat (7) begin
      cyc();
      if (s_trunc) tcnt++;
    end
    chk("trunc_pulses", tcnt, 1);
    chk("trunc_writes", wlog.size() - base, 5);
    if (wlog.size() - base >= 5) begin
      for (int k = 0; k < 4; k++) chk($sformatf("trunc_d%0d", k), wlog[base + k], 8'h10 + 8'(k));
      chk("trunc_next", wlog[base + 4], 8'h20);
    end
    src_nolast[1] = 0;

    // reset mid-packet
    do_reset();
    src_rem[2] = 5;
    drive_srcs();
    cyc();
    cyc();
    cyc();
    wrst = 1'b1;
    src_rem[0] = 1;
    drive_srcs();
    cyc();
    chk("rstm_winc", s_winc, 1'b0);
    wrst = 1'b0;
    cyc();
    chk("rstm_busy", s_busy, 1'b0);
    chk("rstm_winc2", s_winc, 1'b0);
    cyc();
    chk("rstm_gid", s_gid, 2'd0);
    chk("rstm_w", s_winc, 1'b1);
    chk("rstm_data", s_wdata, 8'h00);

    // wrap: ptr=3 with req 3 and req 0 pending
    do_reset();
    src_rem[2] = 1;
    drive_srcs();
    cyc();
    cyc();
    src_rem[3] = 1;
    src_rem[0] = 1;
    drive_srcs();
    base = wlog.size();
    repeat (4) cyc();
    chk("wrap_count", wlog.size() - base, 2);
    if (wlog.size() - base >= 2) begin
      b0 = wlog[base];
      b1 = wlog[base + 1];
      chk("wrap_first", b0[7:4], 4'd3);
      chk("wrap_second", b1[7:4], 4'd0);
    end

    // random traffic against the model
    src_mode = 0;
    do_reset();
    repeat (3000) begin
      req_valid = 4'($urandom);
      for (int i = 0; i < 4; i++) req_last[i] = ($urandom_range(0, 2) == 0);
      req_data = $urandom;
      wfull = ($urandom_range(0, 3) == 0);
      wrst = ($urandom_range(0, 99) == 0);
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
